// File: rtl/store_align_unit_pkg.sv
// Shared encodings for the store alignment path (sizes are also used by the load extend path).
package store_align_unit_pkg;

  // Access size as encoded in the core request.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  // Store sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    FIN   = 2'b11
  } state_e;

  // Unshifted byte-enable mask for an access size; reserved size enables nothing.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    logic [3:0] mask;
    mask = 4'b0000;
    unique case (size)
      SIZE_BYTE: mask = 4'b0001;
      SIZE_HALF: mask = 4'b0011;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane shifter: places right-justified store data and its byte mask into an
// 8-byte window starting at the byte offset. Low half feeds beat 0, high half feeds beat 1.
module store_lane_shift
  import store_align_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [7:0]  strb_win,
  output logic [63:0] data_win
);

  // Shift mask and data left by the byte offset within the two-word window.
  always_comb begin
    strb_win = {4'b0000, lane_mask(size)} << off;
    data_win = {32'd0, data} << {off, 3'b000};
  end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: converts SB/SH/SW requests into word-aligned write beats with
// byte strobes, splitting stores that straddle a word boundary into two beats.
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        done,
  output logic        err
);

  state_e      state;
  logic [7:0]  strb_win;
  logic [63:0] data_win;
  logic [31:0] hi_data;
  logic [3:0]  hi_strb;
  logic        misaligned;
  logic        reject;

  // The window is computed straight from the request so beat 0 can be registered at accept;
  // only the beat-1 half needs to be kept for later.
  store_lane_shift u_lane_shift (
    .size     (req_size),
    .off      (req_addr[1:0]),
    .data     (req_data),
    .strb_win (strb_win),
    .data_win (data_win)
  );

  // Classify the incoming request: reserved size always fails, misalignment only if disallowed.
  always_comb begin
    misaligned = ((req_size == SIZE_HALF) && req_addr[0]) ||
                 ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    reject     = (req_size == SIZE_RSVD) || (!ALLOW_MISALIGNED && misaligned);
  end

  // Sequencer with registered handshake, beat and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      hi_data   <= 32'd0;
      hi_strb   <= 4'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (reject) begin
              err <= 1'b1;
            end else begin
              state     <= BEAT0;
              req_ready <= 1'b0;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= data_win[31:0];
              mem_wstrb <= strb_win[3:0];
              hi_data   <= data_win[63:32];
              hi_strb   <= strb_win[7:4];
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            if (hi_strb != 4'd0) begin
              state     <= BEAT1;
              // Wraps naturally at the top of the address space.
              mem_addr  <= mem_addr + 32'd4;
              mem_wdata <= hi_data;
              mem_wstrb <= hi_strb;
            end else begin
              state     <= FIN;
              mem_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) begin
            state     <= FIN;
            mem_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        FIN: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: directed table, hand-written corner sequences and random stores
// checked against a byte-by-byte reference model.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done;
  logic        err;

  int vecs = 0;
  int errs = 0;

  typedef struct packed {
    logic [1:0]  n;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] d1;
  } exp_t;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    exp_t        e;
  } vec_t;

  vec_t tbl[8];

  store_align_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] n, input logic [31:0] a0, input logic [3:0] s0,
                              input logic [31:0] d0, input logic [31:0] a1,
                              input logic [3:0] s1, input logic [31:0] d1);
    exp_t e;
    e.n = n; e.a0 = a0; e.s0 = s0; e.d0 = d0; e.a1 = a1; e.s1 = s1; e.d1 = d1;
    return e;
  endfunction

  // Reference: write each byte of the store to address addr+i and group bytes by memory word.
  function automatic exp_t model(input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] data);
    exp_t        e;
    int          nb;
    int          lane;
    logic [31:0] ba;
    logic [31:0] w0;
    e  = '0;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    w0 = addr & 32'hFFFF_FFFC;
    e.n  = 2'd1;
    e.a0 = w0;
    e.a1 = w0 + 32'd4;
    for (int i = 0; i < nb; i++) begin
      ba   = addr + 32'(i);
      lane = int'(ba[1:0]);
      if ((ba & 32'hFFFF_FFFC) == w0) begin
        e.s0[lane] = 1'b1;
        e.d0[lane*8 +: 8] = data[i*8 +: 8];
      end else begin
        e.n = 2'd2;
        e.s1[lane] = 1'b1;
        e.d1[lane*8 +: 8] = data[i*8 +: 8];
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Issue one store from IDLE (called at a negedge) and check every beat plus completion.
  task automatic run_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data, input exp_t e, input int fixed_stall,
                           input int stall_pct);
    int          cyc;
    int          got;
    int          stalls;
    int          fs;
    bit          stalled;
    logic [31:0] pa, pd, ea, ed;
    logic [3:0]  ps, es;
    fs = fixed_stall; got = 0; stalls = 0; stalled = 1'b0;
    pa = '0; pd = '0; ps = '0;
    check({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_size = size; req_addr = addr; req_data = data;
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = $urandom;
    cyc = 1;
    while (!done && cyc < 60) begin
      check({tag, "_valid"}, 64'(mem_valid), 64'd1);
      if (stalled) begin
        check({tag, "_hold_addr"}, 64'(mem_addr), 64'(pa));
        check({tag, "_hold_data"}, 64'(mem_wdata), 64'(pd));
        check({tag, "_hold_strb"}, 64'(mem_wstrb), 64'(ps));
      end
      if (fs > 0) begin
        mem_ready = 1'b0;
        fs--;
      end else begin
        mem_ready = ($urandom_range(99) >= stall_pct);
      end
      if (mem_ready) begin
        stalled = 1'b0;
        if (got >= int'(e.n)) begin
          check({tag, "_extra_beat"}, 64'(got + 1), 64'(e.n));
        end else begin
          if (got == 0) begin ea = e.a0; es = e.s0; ed = e.d0; end
          else begin ea = e.a1; es = e.s1; ed = e.d1; end
          check({tag, "_addr"}, 64'(mem_addr), 64'(ea));
          check({tag, "_strb"}, 64'(mem_wstrb), 64'(es));
          check({tag, "_wdata"}, 64'(mem_wdata & lane_bits(es)), 64'(ed & lane_bits(es)));
        end
        got++;
      end else begin
        stalled = 1'b1;
        stalls++;
        pa = mem_addr; pd = mem_wdata; ps = mem_wstrb;
      end
      @(negedge clk);
      cyc++;
    end
    mem_ready = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_beats"}, 64'(got), 64'(e.n));
    check({tag, "_latency"}, 64'(cyc), 64'(int'(e.n) + 1 + stalls));
    check({tag, "_valid_fin"}, 64'(mem_valid), 64'd0);
    check({tag, "_ready_fin"}, 64'(req_ready), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [1:0]  rs;
    logic [31:0] ra, rd;

    tbl[0] = '{2'd0, 32'h0000_0103, 32'h0000_00A5, 0,
               mk(2'd1, 32'h100, 4'b1000, 32'hA500_0000, 32'h0, 4'b0, 32'h0)};
    tbl[1] = '{2'd1, 32'h0000_0202, 32'h0000_BEEF, 0,
               mk(2'd1, 32'h200, 4'b1100, 32'hBEEF_0000, 32'h0, 4'b0, 32'h0)};
    tbl[2] = '{2'd2, 32'h0000_0301, 32'h1122_3344, 0,
               mk(2'd2, 32'h300, 4'b1110, 32'h2233_4400, 32'h304, 4'b0001, 32'h0000_0011)};
    tbl[3] = '{2'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0,
               mk(2'd2, 32'hFFFF_FFFC, 4'b1100, 32'hF00D_0000, 32'h0, 4'b0011, 32'h0000_CAFE)};
    tbl[4] = '{2'd2, 32'h0000_0400, 32'hDEAD_BEEF, 3,
               mk(2'd1, 32'h400, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'b0, 32'h0)};
    tbl[5] = '{2'd1, 32'h0000_0003, 32'h0000_ABCD, 0,
               mk(2'd2, 32'h0, 4'b1000, 32'hCD00_0000, 32'h4, 4'b0001, 32'h0000_00AB)};
    tbl[6] = '{2'd0, 32'h0000_0000, 32'hFFFF_FF5A, 0,
               mk(2'd1, 32'h0, 4'b0001, 32'h0000_005A, 32'h0, 4'b0, 32'h0)};
    tbl[7] = '{2'd1, 32'h0000_0501, 32'h5555_1234, 2,
               mk(2'd1, 32'h500, 4'b0110, 32'h0012_3400, 32'h0, 4'b0, 32'h0)};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_store($sformatf("tbl%0d", i), tbl[i].size, tbl[i].addr, tbl[i].data, tbl[i].e,
                tbl[i].stall, 0);
    end

    // Reserved size: err pulse, no beat, stays ready.
    req_valid = 1'b1; req_size = 2'b11; req_addr = 32'h0000_0600; req_data = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    check("rsvd_err", 64'(err), 64'd1);
    check("rsvd_no_valid", 64'(mem_valid), 64'd0);
    check("rsvd_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    check("rsvd_err_pulse", 64'(err), 64'd0);
    check("rsvd_no_valid2", 64'(mem_valid), 64'd0);
    check("rsvd_no_done", 64'(done), 64'd0);

    // Reset while the second beat of a split store is pending.
    req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h0000_0301; req_data = 32'h1122_3344;
    mem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_beat0", 64'(mem_valid), 64'd1);
    @(negedge clk);
    check("rstmid_beat1_valid", 64'(mem_valid), 64'd1);
    check("rstmid_beat1_addr", 64'(mem_addr), 64'h304);
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rstmid_valid_drop", 64'(mem_valid), 64'd0);
    check("rstmid_no_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_no_done2", 64'(done), 64'd0);
    check("rstmid_ready", 64'(req_ready), 64'd1);
    run_store("post_rst", tbl[0].size, tbl[0].addr, tbl[0].data, tbl[0].e, 0, 0);

    // Random stores with random backpressure against the byte model.
    for (int i = 0; i < 200; i++) begin
      rs = 2'($urandom_range(2));
      ra = $urandom;
      rd = $urandom;
      run_store($sformatf("rnd%0d", i), rs, ra, rd, model(rs, ra, rd), 0, 30);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
